// File: rtl/attention_softmax_norm_reader.sv
// attention_softmax_norm_reader: walks E[tq][tk] and InvSum[tq] through their
// read ports, scales each E by its row's InvSum on an external FP32 multiplier
// and streams P row-major on a valid/ready port.
module attention_softmax_norm_reader #(
  parameter int T       = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  localparam int T_W    = $clog2(T)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              invsum_re,
  output logic [T_W-1:0]    invsum_row,
  input  logic [DATA_W-1:0] invsum_rdata,
  input  logic              invsum_rvalid,
  output logic              e_re,
  output logic [T_W-1:0]    e_tq,
  output logic [T_W-1:0]    e_tk,
  input  logic [DATA_W-1:0] e_rdata,
  input  logic              e_rvalid,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic              mul_done,
  input  logic [DATA_W-1:0] mul_z,
  output logic              p_valid,
  input  logic              p_ready,
  output logic [DATA_W-1:0] p_data,
  output logic [T_W-1:0]    p_row,
  output logic [T_W-1:0]    p_col,
  output logic              p_last
);

  localparam int WC_W = $clog2(TIMEOUT) + 1;
  localparam logic [T_W-1:0] LAST_IDX = T_W'(T - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INV_REQ, S_INV_WAIT, S_E_REQ, S_E_WAIT,
    S_MUL, S_MUL_WAIT, S_OUT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [T_W-1:0]    row_q, col_q;
  logic [DATA_W-1:0] inv_q, e_q, p_q;
  logic [WC_W-1:0]   wait_cnt_q;
  logic              err_q;
  logic              wait_expired, bypass, last_col, last_row;

  // Zero and denormal operands both have a cleared exponent field.
  function automatic logic exp_is_zero(input logic [7:0] exp_f);
    return (exp_f == 8'd0);
  endfunction

  assign wait_expired = (wait_cnt_q == WC_W'(TIMEOUT - 1));
  assign bypass       = exp_is_zero(e_q[30:23]) || exp_is_zero(inv_q[30:23]);
  assign last_col     = (col_q == LAST_IDX);
  assign last_row     = (row_q == LAST_IDX);
  assign err          = err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and all Moore outputs; every output is zero outside its state.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    invsum_re  = 1'b0;
    invsum_row = '0;
    e_re       = 1'b0;
    e_tq       = '0;
    e_tk       = '0;
    mul_start  = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    p_valid    = 1'b0;
    p_data     = '0;
    p_row      = '0;
    p_col      = '0;
    p_last     = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_INV_REQ;
      S_INV_REQ: begin
        busy       = 1'b1;
        invsum_re  = 1'b1;
        invsum_row = row_q;
        state_d    = S_INV_WAIT;
      end
      S_INV_WAIT: begin
        busy = 1'b1;
        if (invsum_rvalid)     state_d = S_E_REQ;
        else if (wait_expired) state_d = S_DONE;
      end
      S_E_REQ: begin
        busy    = 1'b1;
        e_re    = 1'b1;
        e_tq    = row_q;
        e_tk    = col_q;
        state_d = S_E_WAIT;
      end
      S_E_WAIT: begin
        busy = 1'b1;
        if (e_rvalid)          state_d = S_MUL;
        else if (wait_expired) state_d = S_DONE;
      end
      S_MUL: begin
        busy = 1'b1;
        if (bypass) begin
          state_d = S_OUT;
        end else begin
          mul_start = 1'b1;
          mul_a     = e_q;
          mul_b     = inv_q;
          state_d   = S_MUL_WAIT;
        end
      end
      S_MUL_WAIT: begin
        busy  = 1'b1;
        mul_a = e_q;
        mul_b = inv_q;
        if (mul_done)          state_d = S_OUT;
        else if (wait_expired) state_d = S_DONE;
      end
      S_OUT: begin
        busy    = 1'b1;
        p_valid = 1'b1;
        p_data  = p_q;
        p_row   = row_q;
        p_col   = col_q;
        p_last  = last_row && last_col;
        if (p_ready) begin
          if (!last_col)     state_d = S_E_REQ;
          else if (last_row) state_d = S_DONE;
          else               state_d = S_INV_REQ;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Indices, operand latches, product latch, wait counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      col_q      <= '0;
      inv_q      <= '0;
      e_q        <= '0;
      p_q        <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          row_q <= '0;
          col_q <= '0;
          err_q <= 1'b0;
        end
        S_INV_REQ, S_E_REQ: wait_cnt_q <= '0;
        S_INV_WAIT: begin
          if (invsum_rvalid)     inv_q      <= invsum_rdata;
          else if (wait_expired) err_q      <= 1'b1;
          else                   wait_cnt_q <= wait_cnt_q + WC_W'(1);
        end
        S_E_WAIT: begin
          if (e_rvalid)          e_q        <= e_rdata;
          else if (wait_expired) err_q      <= 1'b1;
          else                   wait_cnt_q <= wait_cnt_q + WC_W'(1);
        end
        S_MUL: begin
          wait_cnt_q <= '0;
          if (bypass) p_q <= '0;
        end
        S_MUL_WAIT: begin
          if (mul_done)          p_q        <= mul_z;
          else if (wait_expired) err_q      <= 1'b1;
          else                   wait_cnt_q <= wait_cnt_q + WC_W'(1);
        end
        S_OUT: if (p_ready) begin
          if (last_col) begin
            col_q <= '0;
            if (!last_row) row_q <= row_q + T_W'(1);
          end else begin
            col_q <= col_q + T_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_attention_softmax_norm_reader.sv
// Bench for attention_softmax_norm_reader: memory/multiplier responders with
// random latencies, random backpressure and a row-major expected-beat queue.
module tb_attention_softmax_norm_reader;
  localparam int T  = 4;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int TW = $clog2(T);
  localparam int BW = 2 * TW + 1 + DW;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          busy, done, err;
  logic          invsum_re, e_re, mul_start, mul_done, invsum_rvalid, e_rvalid;
  logic [TW-1:0] invsum_row, e_tq, e_tk, p_row, p_col;
  logic [DW-1:0] invsum_rdata, e_rdata, mul_a, mul_b, mul_z, p_data;
  logic          p_valid, p_ready, p_last;

  always #5 clk = ~clk;

  attention_softmax_norm_reader #(.T(T), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .invsum_re(invsum_re), .invsum_row(invsum_row), .invsum_rdata(invsum_rdata),
    .invsum_rvalid(invsum_rvalid), .e_re(e_re), .e_tq(e_tq), .e_tk(e_tk),
    .e_rdata(e_rdata), .e_rvalid(e_rvalid), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_z(mul_z), .p_valid(p_valid),
    .p_ready(p_ready), .p_data(p_data), .p_row(p_row), .p_col(p_col), .p_last(p_last)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference memories and expected stream
  logic [DW-1:0] e_mem [T][T];
  logic [DW-1:0] inv_mem [T];
  logic [BW-1:0] exp_q [$];

  // InvSum values used here are exact powers of two, so the FP32 product is
  // exact: add exponents, keep E's mantissa. Zero/denormal operands give +0.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ex;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
    ex = int'(a[30:23]) + int'(b[30:23]) - 127;
    return {a[31] ^ b[31], ex[7:0], a[22:0]};
  endfunction

  function automatic logic [31:0] gen_e(input bit allow_zero);
    logic [7:0] ex;
    ex = 8'($urandom_range(150, 100));
    if (allow_zero && $urandom_range(5) == 0) ex = 8'h0;
    return {1'($urandom), ex, 23'($urandom)};
  endfunction

  function automatic logic [31:0] gen_inv();
    return {1'b0, 8'($urandom_range(126, 120)), 23'h0};
  endfunction

  task automatic fill_random(input bit allow_zero);
    for (int r = 0; r < T; r++) begin
      inv_mem[r] = gen_inv();
      for (int c = 0; c < T; c++) e_mem[r][c] = gen_e(allow_zero);
    end
  endtask

  task automatic build_expected();
    exp_q.delete();
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++)
        exp_q.push_back({TW'(r), TW'(c), (r == T - 1 && c == T - 1), ref_mul(e_mem[r][c], inv_mem[r])});
  endtask

  function automatic logic [127:0] outs_vec();
    return 128'({busy, done, err, invsum_re, invsum_row, e_re, e_tq, e_tk, mul_start,
                 mul_a, mul_b, p_valid, p_data, p_row, p_col, p_last});
  endfunction

  // Environment knobs and counters
  bit            stray_en = 0, rdy_rand = 0, hold_en = 0, e_held = 0;
  logic [TW-1:0] hold_r = '0, hold_c = '0, stall_r = '0, stall_c = '0;
  int            stall_left = 0;
  int            nbeats = 0, mul_r2 = 0, viol = 0;
  int            ic = 0, ec = 0, mc = 0;
  logic [DW-1:0] inv_pend, e_pend, m_pend;
  logic [TW-1:0] cur_row = '0, cur_col = '0;

  // Responders, backpressure and output monitor, all on the falling edge.
  initial begin
    invsum_rvalid = 0; e_rvalid = 0; mul_done = 0; p_ready = 0;
    invsum_rdata = '0; e_rdata = '0; mul_z = '0;
    forever begin
      @(negedge clk);
      invsum_rvalid = 0; e_rvalid = 0; mul_done = 0;
      if (ic > 0) begin
        ic--;
        if (ic == 0) begin invsum_rvalid = 1; invsum_rdata = inv_pend; end
      end else if (stray_en && $urandom_range(7) == 0) begin
        invsum_rvalid = 1; invsum_rdata = $urandom;
      end
      if (ec > 0) begin
        ec--;
        if (ec == 0) begin e_rvalid = 1; e_rdata = e_pend; end
      end else if (stray_en && !e_held && $urandom_range(7) == 0) begin
        e_rvalid = 1; e_rdata = $urandom;
      end
      if (mc > 0) begin
        mc--;
        if (mc == 0) begin mul_done = 1; mul_z = m_pend; end
      end else if (stray_en && $urandom_range(7) == 0) begin
        mul_done = 1; mul_z = $urandom;
      end
      if (invsum_re) begin
        cur_row  = invsum_row;
        inv_pend = inv_mem[invsum_row];
        ic       = $urandom_range(3, 1);
      end
      if (e_re) begin
        cur_row = e_tq;
        cur_col = e_tk;
        if (hold_en && e_tq == hold_r && e_tk == hold_c) begin
          e_held = 1;
        end else begin
          e_pend = e_mem[e_tq][e_tk];
          ec     = $urandom_range(3, 1);
        end
      end
      if (mul_start) begin
        check_eq("mul_ops", 128'({mul_a, mul_b}), 128'({e_mem[cur_row][cur_col], inv_mem[cur_row]}));
        if (cur_row == TW'(2)) mul_r2++;
        m_pend = ref_mul(mul_a, mul_b);
        mc     = $urandom_range(4, 1);
      end
      if (p_valid && stall_left > 0 && p_row == stall_r && p_col == stall_c) begin
        p_ready = 0;
        stall_left--;
      end else begin
        p_ready = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
      end
      if (!rst && p_valid) begin
        if (exp_q.size() == 0) check_eq("beat_extra", 128'(1), 128'(0));
        else check_eq("beat", 128'({p_row, p_col, p_last, p_data}), 128'(exp_q[0]));
        if (p_ready) begin
          nbeats++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      if (e_re && p_valid) viol++;
    end
  end

  task automatic run_pass(input string nm, input logic exp_err, input int exp_beats, input int hold_cycles);
    int n;
    nbeats = 0;
    start  = 1;
    n      = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({nm, "_done"}, 128'(done), 128'(1));
    check_eq({nm, "_err"}, 128'(err), 128'(exp_err));
    check_eq({nm, "_busy"}, 128'(busy), 128'(0));
    check_eq({nm, "_beats"}, 128'(nbeats), 128'(exp_beats));
    if (!exp_err) check_eq({nm, "_q_left"}, 128'(exp_q.size()), 128'(0));
    if (hold_cycles > 0) begin
      repeat (hold_cycles) @(negedge clk);
      check_eq({nm, "_held_done"}, 128'({done, busy}), 128'(2'b10));
    end
    start = 0;
    repeat (2) @(negedge clk);
    check_eq({nm, "_idle"}, 128'({done, busy}), 128'(0));
  endtask

  initial begin
    int n;
    rst = 1; start = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", outs_vec(), 128'(0));
    rst = 0;
    @(negedge clk);

    // Uniform tile: every beat is 1.0 * 0.25
    for (int r = 0; r < T; r++) begin
      inv_mem[r] = 32'h3E800000;
      for (int c = 0; c < T; c++) e_mem[r][c] = 32'h3F800000;
    end
    build_expected();
    run_pass("uniform", 1'b0, T * T, 0);

    // Random data with zero/denormal E, random backpressure, long stall on (1,2)
    stray_en = 1; rdy_rand = 1;
    fill_random(1'b1);
    build_expected();
    stall_r = TW'(1); stall_c = TW'(2); stall_left = 5; viol = 0;
    run_pass("random", 1'b0, T * T, 0);
    check_eq("random_stall_used", 128'(stall_left), 128'(0));
    check_eq("random_no_read_in_out", 128'(viol), 128'(0));

    // Masked row: InvSum[2] = 0 bypasses the multiplier for the whole row
    fill_random(1'b0);
    inv_mem[2] = 32'h0;
    build_expected();
    mul_r2 = 0;
    run_pass("masked", 1'b0, T * T, 0);
    check_eq("masked_row2_mul", 128'(mul_r2), 128'(0));

    // E read for (0,1) never answered: timeout, then start held through done
    fill_random(1'b1);
    build_expected();
    hold_r = TW'(0); hold_c = TW'(1); hold_en = 1;
    run_pass("timeout", 1'b1, 1, 5);
    hold_en = 0; e_held = 0;
    build_expected();
    run_pass("rerun", 1'b0, T * T, 0);

    // Reset while waiting on the multiplier in row 1
    fill_random(1'b0);
    build_expected();
    start = 1;
    n = 0;
    while (!(mul_start && cur_row == TW'(1)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_reach_mul_row1", 128'(mul_start && cur_row == TW'(1)), 128'(1));
    @(negedge clk);
    rst = 1; start = 0;
    @(negedge clk);
    check_eq("rst_outs_zero", outs_vec(), 128'(0));
    rst = 0;
    repeat (6) @(negedge clk);
    check_eq("rst_late_done_ignored", outs_vec(), 128'(0));
    build_expected();
    run_pass("after_rst", 1'b0, T * T, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
